// File: rtl/npc_pkg.sv
// Shared fetch-unit types and defaults: FSM state encoding, reset PC and datapath width.
package npc_pkg;

  localparam int unsigned NPC_XLEN     = 32;
  localparam logic [31:0] NPC_RESET_PC = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_ERR  = 3'd4
  } fetch_state_e;

  // True when the two low address bits describe a word-aligned address.
  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues one word fetch at a time, holds the returned
// instruction for execute, and follows the execute stage's next-PC.
module ifu_fetch
  import npc_pkg::*;
#(
  parameter int unsigned      XLEN     = NPC_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(NPC_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic [XLEN-1:0] dnpc,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;

  // The request address is the PC register itself, so it cannot move while stalled.
  assign imem_req_addr = pc_q;

  // Single state register plus datapath; every output flop changes with its state transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      pc_q           <= RESET_PC;
      inst           <= '0;
      inst_pc        <= '0;
      fault          <= 1'b0;
      fault_pc       <= '0;
      imem_req_valid <= 1'b0;
      inst_valid     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q        <= S_REQ;
          imem_req_valid <= 1'b1;
        end

        S_REQ: begin
          if (imem_req_ready) begin
            state_q        <= S_WAIT;
            imem_req_valid <= 1'b0;
          end
        end

        // Responses only count here, so one arriving alongside its request is ignored.
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (imem_rsp_err) begin
              state_q  <= S_ERR;
              fault    <= 1'b1;
              fault_pc <= pc_q;
            end else begin
              state_q    <= S_HOLD;
              inst       <= imem_rsp_data;
              inst_pc    <= pc_q;
              inst_valid <= 1'b1;
            end
          end
        end

        S_HOLD: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            if (word_aligned(dnpc[1:0])) begin
              state_q        <= S_REQ;
              pc_q           <= dnpc;
              imem_req_valid <= 1'b1;
            end else begin
              state_q  <= S_ERR;
              fault    <= 1'b1;
              fault_pc <= dnpc;
            end
          end
        end

        S_ERR: begin
          state_q <= S_ERR;
        end

        default: begin
          state_q        <= S_ERR;
          fault          <= 1'b1;
          imem_req_valid <= 1'b0;
          inst_valid     <= 1'b0;
        end
      endcase
    end
  end

  // Structural invariants of the fetch handshake.
  a_req_aligned: assert property (@(posedge clk) disable iff (!rst)
    imem_req_valid |-> word_aligned(imem_req_addr[1:0]));

  a_one_side_valid: assert property (@(posedge clk) disable iff (!rst)
    !(imem_req_valid && inst_valid));

  a_fault_quiet: assert property (@(posedge clk) disable iff (!rst)
    fault |-> (!imem_req_valid && !inst_valid));

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus randomized fetch streams
// against a transaction-level model of the fetch sequence and instruction memory.
module tb_ifu_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] dnpc;
  logic        fault;
  logic [31:0] fault_pc;

  int tests_run    = 0;
  int tests_failed = 0;

  ifu_fetch #(.RESET_PC(32'h8000_0000), .XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .dnpc           (dnpc),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: contents are a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0000_0413;
  endfunction

  // Advance one clock; outputs are then observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    imem_rsp_data  = 32'h0;
    inst_ready     = 1'b0;
    dnpc           = 32'h0;
  endtask

  // Reset for a few cycles, release, and advance into the first request cycle.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  // One complete fetch transaction starting in the request cycle for pc.
  task automatic do_fetch(input logic [31:0] pc, input int req_stall, input int rsp_lat,
                          input int hold_stall, input bit rsp_fault,
                          input logic [31:0] next_pc, input string tag);
    logic [31:0] word;
    word = mem_word(pc);

    tests_run++;
    if ({imem_req_valid, imem_req_addr, inst_valid, fault} !== {1'b1, pc, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL %s req_entry: valid=%b addr=%h inst_valid=%b fault=%b, want 1 %h 0 0",
               tag, imem_req_valid, imem_req_addr, inst_valid, fault, pc);
    end

    // Stalled request with junk responses that must be ignored.
    for (int i = 0; i < req_stall; i++) begin
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rsp_err   = 1'($urandom_range(0, 1));
      imem_rsp_data  = $urandom;
      step();
      tests_run++;
      if ({imem_req_valid, imem_req_addr, inst_valid, fault} !== {1'b1, pc, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL %s req_stall[%0d]: valid=%b addr=%h inst_valid=%b fault=%b, want 1 %h 0 0",
                 tag, i, imem_req_valid, imem_req_addr, inst_valid, fault, pc);
      end
    end

    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'($urandom_range(0, 1));
    imem_rsp_err   = 1'($urandom_range(0, 1));
    imem_rsp_data  = $urandom;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    tests_run++;
    if ({imem_req_valid, inst_valid, fault} !== 3'b000) begin
      tests_failed++;
      $display("FAIL %s accept: req_valid=%b inst_valid=%b fault=%b, want 0 0 0",
               tag, imem_req_valid, inst_valid, fault);
    end

    for (int i = 0; i < rsp_lat; i++) begin
      imem_rsp_data = $urandom;
      step();
      tests_run++;
      if ({imem_req_valid, inst_valid, fault} !== 3'b000) begin
        tests_failed++;
        $display("FAIL %s wait[%0d]: req_valid=%b inst_valid=%b fault=%b, want 0 0 0",
                 tag, i, imem_req_valid, inst_valid, fault);
      end
    end

    imem_rsp_valid = 1'b1;
    imem_rsp_err   = rsp_fault;
    imem_rsp_data  = rsp_fault ? $urandom : word;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    imem_rsp_data  = $urandom;

    if (rsp_fault) begin
      tests_run++;
      if ({fault, fault_pc, inst_valid, imem_req_valid} !== {1'b1, pc, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL %s rsp_err: fault=%b fault_pc=%h inst_valid=%b req_valid=%b, want 1 %h 0 0",
                 tag, fault, fault_pc, inst_valid, imem_req_valid, pc);
      end
      return;
    end

    tests_run++;
    if ({inst_valid, inst, inst_pc, imem_req_valid, fault} !== {1'b1, word, pc, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL %s hold_entry: inst_valid=%b inst=%h inst_pc=%h req_valid=%b fault=%b, want 1 %h %h 0 0",
               tag, inst_valid, inst, inst_pc, imem_req_valid, fault, word, pc);
    end

    for (int i = 0; i < hold_stall; i++) begin
      inst_ready = 1'b0;
      dnpc       = $urandom;
      step();
      tests_run++;
      if ({inst_valid, inst, inst_pc, imem_req_valid} !== {1'b1, word, pc, 1'b0}) begin
        tests_failed++;
        $display("FAIL %s hold_stall[%0d]: inst_valid=%b inst=%h inst_pc=%h req_valid=%b, want 1 %h %h 0",
                 tag, i, inst_valid, inst, inst_pc, imem_req_valid, word, pc);
      end
    end

    inst_ready = 1'b1;
    dnpc       = next_pc;
    step();
    inst_ready = 1'b0;
    dnpc       = $urandom;

    if (next_pc[1:0] == 2'b00) begin
      tests_run++;
      if ({imem_req_valid, imem_req_addr, inst_valid, fault} !== {1'b1, next_pc, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL %s next_req: valid=%b addr=%h inst_valid=%b fault=%b, want 1 %h 0 0",
                 tag, imem_req_valid, imem_req_addr, inst_valid, fault, next_pc);
      end
    end else begin
      tests_run++;
      if ({fault, fault_pc, imem_req_valid, inst_valid} !== {1'b1, next_pc, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL %s misalign: fault=%b fault_pc=%h req_valid=%b inst_valid=%b, want 1 %h 0 0",
                 tag, fault, fault_pc, imem_req_valid, inst_valid, next_pc);
      end
    end
  endtask

  // Fault state is sticky: random traffic must not revive fetching.
  task automatic err_hold(input int n, input logic [31:0] exp_fpc, input string tag);
    for (int i = 0; i < n; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rsp_err   = 1'($urandom_range(0, 1));
      imem_rsp_data  = $urandom;
      inst_ready     = 1'($urandom_range(0, 1));
      dnpc           = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      step();
      tests_run++;
      if ({fault, fault_pc, imem_req_valid, inst_valid} !== {1'b1, exp_fpc, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL %s sticky[%0d]: fault=%b fault_pc=%h req_valid=%b inst_valid=%b, want 1 %h 0 0",
                 tag, i, fault, fault_pc, imem_req_valid, inst_valid, exp_fpc);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    tests_run++;
    if ({imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fault, fault_pc}
        !== {1'b0, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_values: req_valid=%b addr=%h inst_valid=%b inst=%h inst_pc=%h fault=%b fault_pc=%h, want 0 80000000 0 0 0 0 0",
               imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fault, fault_pc);
    end
    rst = 1'b1;
    step();
    tests_run++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0000}) begin
      tests_failed++;
      $display("FAIL reset_first_req: valid=%b addr=%h, want 1 80000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_first_fetch();
    do_reset();
    do_fetch(32'h8000_0000, 0, 0, 0, 1'b0, 32'h8000_0004, "first_fetch");
    do_fetch(32'h8000_0004, 0, 0, 0, 1'b0, 32'h8000_0008, "first_fetch2");
  endtask

  task automatic test_req_stall();
    do_reset();
    do_fetch(32'h8000_0000, 5, 0, 0, 1'b0, 32'h8000_0004, "req_stall");
  endtask

  task automatic test_hold_stall();
    do_reset();
    do_fetch(32'h8000_0000, 0, 1, 4, 1'b0, 32'h8000_0010, "hold_stall");
    do_fetch(32'h8000_0010, 1, 2, 0, 1'b0, 32'h8000_0014, "hold_next");
  endtask

  task automatic test_misaligned();
    do_reset();
    do_fetch(32'h8000_0000, 0, 0, 1, 1'b0, 32'h8000_0006, "misaligned");
    err_hold(6, 32'h8000_0006, "misaligned");
  endtask

  task automatic test_rsp_err();
    do_reset();
    do_fetch(32'h8000_0000, 0, 0, 0, 1'b0, 32'h8000_0004, "rsp_err_pre");
    do_fetch(32'h8000_0004, 1, 1, 0, 1'b1, 32'h0, "rsp_err");
    err_hold(6, 32'h8000_0004, "rsp_err");
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    do_fetch(32'h8000_0000, 0, 0, 0, 1'b0, 32'h8000_0020, "rst_wait_pre");
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({imem_req_valid, inst_valid, imem_req_addr, inst, inst_pc, fault}
        !== {1'b0, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL rst_async: req_valid=%b inst_valid=%b addr=%h inst=%h inst_pc=%h fault=%b, want 0 0 80000000 0 0 0",
               imem_req_valid, inst_valid, imem_req_addr, inst, inst_pc, fault);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    step();
    imem_rsp_valid = 1'b0;
    rst = 1'b1;
    step();
    tests_run++;
    if ({imem_req_valid, imem_req_addr, inst_valid, inst} !== {1'b1, 32'h8000_0000, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL rst_restart: valid=%b addr=%h inst_valid=%b inst=%h, want 1 80000000 0 0",
               imem_req_valid, imem_req_addr, inst_valid, inst);
    end
    do_fetch(32'h8000_0000, 0, 0, 0, 1'b0, 32'h8000_0004, "rst_after");
  endtask

  task automatic test_wrap();
    do_reset();
    do_fetch(32'h8000_0000, 0, 0, 0, 1'b0, 32'hFFFF_FFFC, "wrap_a");
    do_fetch(32'hFFFF_FFFC, 0, 0, 0, 1'b0, 32'hFFFF_FFFC + 32'd4, "wrap_b");
    do_fetch(32'h0000_0000, 0, 0, 0, 1'b0, 32'h0000_0004, "wrap_c");
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    do_reset();
    pc = 32'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      do_fetch(pc, 0, 0, 0, 1'b0, pc + 32'd4, "back_to_back");
      pc = pc + 32'd4;
    end
  endtask

  // Randomized stream: model tracks the expected PC sequence, ending in a misaligned jump.
  task automatic test_random();
    logic [31:0] pc;
    logic [31:0] nxt;
    do_reset();
    pc = 32'h8000_0000;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       nxt = pc + 32'd4;
        1:       nxt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        default: nxt = pc + {$urandom_range(0, 255), 2'b00};
      endcase
      do_fetch(pc, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               1'b0, nxt, "random");
      pc = nxt;
    end
    nxt = {$urandom_range(0, 32'h3FFF_FFFF), 2'($urandom_range(1, 3))};
    do_fetch(pc, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
             1'b0, nxt, "random_end");
    err_hold(3, nxt, "random_end");
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_first_fetch();
    test_req_stall();
    test_hold_stall();
    test_misaligned();
    test_rsp_err();
    test_reset_in_wait();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h8000_0000, address of first fetch after reset.
REQ-002 Parameter XLEN, 32, width of address and instruction data.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 imem_req_addr  output  32  fetch address; word aligned.
REQ-008 imem_rsp_valid  input  1  response data valid this cycle.
REQ-009 imem_rsp_data  input  32  fetched instruction word.
REQ-010 imem_rsp_err  input  1  access fault; qualified by imem_rsp_valid.
REQ-011 inst_valid  output  1  instruction available to decode/execute stage.
REQ-012 inst_ready  input  1  execute stage consumes instruction this cycle.
REQ-013 inst  output  32  held instruction word.
REQ-014 inst_pc  output  32  address of held instruction.
REQ-015 dnpc  input  32  next PC from execute stage; sampled on inst_valid&inst_ready.
REQ-016 fault  output  1  sticky fetch-fault flag.
REQ-017 fault_pc  output  32  PC that caused the fault.

Function
REQ-018 FSM states: IDLE, REQ, WAIT, HOLD, ERR.
REQ-019 IDLE: entered on reset; next cycle unconditionally goes to REQ.
REQ-020 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready go to WAIT; addr stable while stalled.
REQ-021 WAIT: imem_req_valid=0; on imem_rsp_valid&!imem_rsp_err latch inst<=imem_rsp_data, go to HOLD; on imem_rsp_valid&imem_rsp_err go to ERR.
REQ-022 imem_rsp_valid outside WAIT is ignored; response never accepted in the same cycle as its request.
REQ-023 HOLD: inst_valid=1, inst and inst_pc stable until inst_valid&inst_ready.
REQ-024 On inst_valid&inst_ready: if dnpc[1:0]==0, pc<=dnpc and go to REQ; else fault_pc<=dnpc and go to ERR.
REQ-025 ERR: fault=1, imem_req_valid=0, inst_valid=0; state held until reset.
REQ-026 On rsp error, fault_pc<=pc of the failed fetch.
REQ-027 Minimum fetch-to-fetch period: 3 cycles (REQ, WAIT, HOLD) with zero-wait memory and inst_ready=1.
REQ-028 PC arithmetic is XLEN-bit; wrap-around of dnpc from 32'hFFFF_FFFC to 0 is legal and not a fault.
REQ-029 inst_pc always equals the imem_req_addr that produced inst.

Reset
REQ-030 Reset asserted at any time, including mid-request, returns FSM to IDLE asynchronously; any outstanding response is dropped.
REQ-031 Reset values: pc=RESET_PC, inst=0, inst_pc=0, fault=0, fault_pc=0, all valids 0.

Structure
REQ-032 Shared package npc_pkg holds the FSM state enum, RESET_PC default, and XLEN.
REQ-033 No sub-module; single flat module with one state register and datapath registers.

Verification
REQ-034 Release reset, memory ready=1, rsp next cycle data 32'h00000413 -> req addr 32'h80000000, inst_valid in 3rd cycle, inst_pc=32'h80000000.
REQ-035 Hold imem_req_ready=0 for 5 cycles -> imem_req_valid=1 and addr unchanged throughout; single request accepted.
REQ-036 Hold inst_ready=0 for 4 cycles, then accept with dnpc=32'h80000010 -> inst stable, next req addr 32'h80000010.
REQ-037 Accept with dnpc=32'h80000006 -> fault=1, fault_pc=32'h80000006, no further requests.
REQ-038 Response with imem_rsp_err=1 at pc 32'h80000004 -> fault=1, fault_pc=32'h80000004, inst_valid stays 0.
REQ-039 Assert rst in WAIT, deliver rsp during reset -> response dropped; after release, fetch restarts at 32'h80000000.
